pl_if_stage: RTL

PL_IF_STAGE -- requirements
Module: pl_if_stage

---
 rtl/pl_if_stage.sv | 96 +++++++++
 1 files changed

// File: rtl/pl_if_stage.sv
// Instruction-fetch stage with an IF/ID pipeline register.
// The stage owns the fetch PC. It remembers a redirect that arrives while the
// pipe is stalled and applies it on release. It turns wrong-path fetches into
// bubbles and counts the instructions it delivers to decode.
module pl_if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_inst,
   output logic [31:0] pc,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   output logic        id_valid,
   output logic [31:0] fetch_count
);

   // PEND means a redirect arrived under stall and has not been applied yet.
   typedef enum logic {
      NORMAL = 1'b0,
      PEND   = 1'b1
   } state_t;

   state_t      state;
   logic [31:0] pend_pc;
   logic [31:0] pc_plus4;
   logic [31:0] target_pc;
   logic        squash;
   logic        load;

   // The instruction memory is read combinationally at the current PC.
   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;   // plain unsigned add, so it wraps at 2^32

   // Targets are word-aligned: the low two bits of a jump target are dropped.
   assign target_pc = {redirect_pc[31:2], 2'b00};

   // Whatever is being fetched this cycle is wrong-path when a jump is applied now.
   assign squash = !stall && (redirect || (state == PEND));
   assign load   = !flush && !stall && !squash;

   // PC selection and the pending-redirect FSM, updated together.
   // NOTE: every register here uses <= so all of them sample the pre-edge values;
   // with blocking '=' the order of the statements would change the behaviour.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc      <= RESET_PC;
         pend_pc <= 32'h0000_0000;
         state   <= NORMAL;
      end else if (!stall) begin
         // The first unstalled cycle always leaves PEND. A new redirect wins over pend_pc.
         state <= NORMAL;
         if (redirect)
            pc <= target_pc;
         else if (state == PEND)
            pc <= pend_pc;
         else
            pc <= pc_plus4;
      end else if (redirect) begin
         // Stalled: keep the PC. Remember the newest target for release.
         pend_pc <= target_pc;
         state   <= PEND;
      end
   end

   // IF/ID register: flush or squash inserts a bubble, stall holds, otherwise load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_inst     <= NOP_INST;
         id_pc       <= 32'h0000_0000;
         id_pc4      <= 32'h0000_0000;
         id_valid    <= 1'b0;
         fetch_count <= 32'h0000_0000;
      end else if (flush || squash) begin
         // squash already implies !stall, so this keeps flush above stall and squash.
         id_inst  <= NOP_INST;
         id_pc    <= 32'h0000_0000;
         id_pc4   <= 32'h0000_0000;
         id_valid <= 1'b0;
      end else if (load) begin
         id_inst     <= imem_inst;
         id_pc       <= pc;
         id_pc4      <= pc_plus4;
         id_valid    <= 1'b1;
         fetch_count <= fetch_count + 32'd1;
      end
   end

endmodule
